emif_cal_debug_calbus_bridge: RTL



---
 rtl/emif_cal_bridge_pkg.sv | 34 +++
 rtl/emif_cal_lat_counter.sv | 32 +++
 rtl/emif_cal_debug_calbus_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/emif_cal_bridge_pkg.sv
// Package for the EMIF calibration debug -> calbus bridge.
// Holds the bridge FSM state type, the channel-select width, the latency
// counter width and the byte-lane merge helper used for partial writes.
package emif_cal_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RMW_WAIT,
        ST_WR,
        ST_RESP
    } state_e;

    localparam int CHAN_SEL_WIDTH = 4;
    localparam int LAT_W          = 3;    // enough for RD_LATENCY up to 7
    localparam int MAX_DW         = 256;  // widest data path be_merge handles
    localparam int MAX_BE         = MAX_DW / 8;

    // Byte-lane merge: enabled lanes take new_d, the rest keep old_d.
    // Callers zero-extend to MAX_DW and truncate the result back.
    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0] old_d,
        input logic [MAX_DW-1:0] new_d,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = old_d;
        for (int b = 0; b < MAX_BE; b++) begin
            if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/emif_cal_lat_counter.sv
// Loadable down-counter used to time the calbus read latency.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   load_i      load load_val_i this cycle
//   load_val_i  remaining wait cycles after the load
//   done_o      count has reached zero
module emif_cal_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/emif_cal_debug_calbus_bridge.sv
// Bridge from the EMIF calibration debug Avalon-MM port to NUM_CALBUS
// calibration buses. One outstanding command; channel chosen by the top
// address nibble; partial writes done as read-modify-write; unmapped
// channels and read+write collisions bump a saturating error counter.
// Ports:
//   cal_debug_*   Avalon-MM slave (read/write/addr/data/byteenable in,
//                 waitrequest/read_data/read_data_valid out)
//   calbus_*      per-channel strobes, address and write data out (flattened,
//                 channel i in slice i), read data in
//   err_count     saturating error counter, cleared only by reset
module emif_cal_debug_calbus_bridge
    import emif_cal_bridge_pkg::*;
#(
    parameter int                    NUM_CALBUS        = 2,
    parameter int                    CALBUS_ADDR_WIDTH = 20,
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    RD_LATENCY        = 2,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA          = 32'hDEAD_BEEF
) (
    input  logic                                  cal_debug_clk,
    input  logic                                  cal_debug_reset_n,
    input  logic                                  cal_debug_read,
    input  logic                                  cal_debug_write,
    input  logic [CALBUS_ADDR_WIDTH+3:0]          cal_debug_addr,
    input  logic [DATA_WIDTH-1:0]                 cal_debug_write_data,
    input  logic [DATA_WIDTH/8-1:0]               cal_debug_byteenable,
    output logic                                  cal_debug_waitrequest,
    output logic [DATA_WIDTH-1:0]                 cal_debug_read_data,
    output logic                                  cal_debug_read_data_valid,
    output logic [NUM_CALBUS-1:0]                 calbus_read,
    output logic [NUM_CALBUS-1:0]                 calbus_write,
    output logic [NUM_CALBUS*CALBUS_ADDR_WIDTH-1:0] calbus_address,
    output logic [NUM_CALBUS*DATA_WIDTH-1:0]      calbus_wdata,
    input  logic [NUM_CALBUS*DATA_WIDTH-1:0]      calbus_rdata,
    output logic [7:0]                            err_count
);

    localparam int AW    = CALBUS_ADDR_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int BW    = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_CALBUS > 1) ? $clog2(NUM_CALBUS) : 1;

    state_e                       state_q, state_d;
    logic                         wait_q, valid_q;
    logic [DW-1:0]                rdata_q;
    logic [NUM_CALBUS-1:0]        rd_strb_q, wr_strb_q;
    logic [NUM_CALBUS-1:0][AW-1:0] addr_slc_q;
    logic [NUM_CALBUS-1:0][DW-1:0] wdata_slc_q;
    logic [NUM_CALBUS-1:0][DW-1:0] rdata_slc;
    logic [7:0]                   err_q;
    logic [DW-1:0]                wdata_q;
    logic [BW-1:0]                be_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         map_q;

    logic [CHAN_SEL_WIDTH-1:0]    ch_in;
    logic [IDX_W-1:0]             idx_in;
    logic                         map_in, accept, be_full, be_zero, err_ev;
    logic                         cnt_load, cnt_done;
    logic [LAT_W-1:0]             cnt_val;

    assign rdata_slc = calbus_rdata;
    assign ch_in     = cal_debug_addr[AW+CHAN_SEL_WIDTH-1:AW];
    assign idx_in    = ch_in[IDX_W-1:0];
    assign map_in    = ({1'b0, ch_in} < 5'(NUM_CALBUS));
    // waitrequest is low only in IDLE, so this also implies state_q==IDLE
    assign accept    = (cal_debug_read | cal_debug_write) & ~wait_q;
    assign be_full   = &cal_debug_byteenable;
    assign be_zero   = ~|cal_debug_byteenable;
    assign err_ev    = accept & (~map_in | (cal_debug_read & cal_debug_write));

    emif_cal_lat_counter #(.W(LAT_W)) u_lat (
        .clk_i      (cal_debug_clk),
        .rst_ni     (cal_debug_reset_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    // Read waits RD_LATENCY cycles and samples in RESP; RMW samples on the
    // last wait cycle so the write strobe lands one cycle later in WR.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = LAT_W'(RD_LATENCY - 1);
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cal_debug_write) begin
                        if (map_in && !be_full && !be_zero) begin
                            state_d  = ST_RMW_WAIT;
                            cnt_load = 1'b1;
                            cnt_val  = LAT_W'(RD_LATENCY);
                        end else begin
                            state_d = ST_WR;
                        end
                    end else if (map_in) begin
                        state_d  = ST_RD_WAIT;
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RD_WAIT:  if (cnt_done) state_d = ST_RESP;
            ST_RMW_WAIT: if (cnt_done) state_d = ST_WR;
            ST_WR:       state_d = ST_IDLE;
            ST_RESP:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cal_debug_clk) begin
        if (!cal_debug_reset_n) begin
            state_q     <= ST_IDLE;
            wait_q      <= 1'b1;
            valid_q     <= 1'b0;
            rdata_q     <= '0;
            rd_strb_q   <= '0;
            wr_strb_q   <= '0;
            addr_slc_q  <= '0;
            wdata_slc_q <= '0;
            err_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            idx_q       <= '0;
            map_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= (state_d != ST_IDLE);
            valid_q   <= 1'b0;
            rd_strb_q <= '0;
            wr_strb_q <= '0;
            if (err_ev && err_q != 8'hFF) err_q <= err_q + 8'd1;

            if (accept) begin
                wdata_q <= cal_debug_write_data;
                be_q    <= cal_debug_byteenable;
                idx_q   <= idx_in;
                map_q   <= map_in;
                if (map_in) begin
                    if (cal_debug_write) begin
                        if (be_full) begin
                            wr_strb_q[idx_in]   <= 1'b1;
                            addr_slc_q[idx_in]  <= cal_debug_addr[AW-1:0];
                            wdata_slc_q[idx_in] <= cal_debug_write_data;
                        end else if (!be_zero) begin
                            rd_strb_q[idx_in]   <= 1'b1;
                            addr_slc_q[idx_in]  <= cal_debug_addr[AW-1:0];
                        end
                    end else begin
                        rd_strb_q[idx_in]  <= 1'b1;
                        addr_slc_q[idx_in] <= cal_debug_addr[AW-1:0];
                    end
                end
            end

            if (state_q == ST_RESP) begin
                rdata_q <= map_q ? rdata_slc[idx_q] : ERR_DATA;
                valid_q <= 1'b1;
            end

            if (state_q == ST_RMW_WAIT && cnt_done) begin
                wr_strb_q[idx_q]   <= 1'b1;
                wdata_slc_q[idx_q] <= DW'(be_merge(MAX_DW'(rdata_slc[idx_q]),
                                                   MAX_DW'(wdata_q),
                                                   MAX_BE'(be_q)));
            end
        end
    end

    assign cal_debug_waitrequest     = wait_q;
    assign cal_debug_read_data       = rdata_q;
    assign cal_debug_read_data_valid = valid_q;
    assign calbus_read               = rd_strb_q;
    assign calbus_write              = wr_strb_q;
    assign calbus_address            = addr_slc_q;
    assign calbus_wdata              = wdata_slc_q;
    assign err_count                 = err_q;

endmodule
